wide_adder_seq: RTL and testbench
=================================

# wide_adder_seq

Multi-cycle sequencer that performs a W = N×CHUNKS bit addition using a single N-bit `adder_n` instance, one N-bit chunk per clock, least-significant chunk first, with a registered carry between chunks. It sits between a requester and a consumer using valid/ready handshakes. It trades latency for area when wide operands would otherwise need a full-width ripple adder.

## Interface
- `N`, 32, chunk width; this is the width of the shared `adder_n`.
- `CHUNKS`, 4, number of chunks; must be ≥ 1; W = N×CHUNKS.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: requester presents an operation.
- `in_ready` output 1: block accepts an operation.
- `a` input W: first operand.
- `b` input W: second operand.
- `c_in` input 1: carry into bit 0.
- `sub` input 1: present only with `WIDE_ADDER_SEQ_SUB_EN`; selects a − b.
- `out_valid` output 1: `sum`/`c_out` hold a completed result.
- `out_ready` input 1: consumer takes the result.
- `sum` output W: result register.
- `c_out` output 1: carry out of bit W−1.

## Operation
- The state machine `state_t` has three states: S_IDLE, S_BUSY and S_DONE.
- `in_ready` = (state == S_IDLE) and not `rst`.
- `out_valid` = (state == S_DONE).
- **S_IDLE:**
  - On `in_valid & in_ready`, latch `a`, `b` (and `sub`) into operand registers.
  - Load `carry_q` ← `c_in`, clear chunk counter `idx` to 0, then go to S_BUSY.
  - Otherwise hold.
- **S_BUSY:**
  - The shared adder sees `a_q[idx*N +: N]`, `b_q[idx*N +: N]` and `carry_q`.
  - Each edge writes the adder sum into `sum[idx*N +: N]`, `carry_q` ← adder carry out, and `idx` ← `idx`+1.
  - On the edge with `idx == CHUNKS−1`, go to S_DONE. Inputs are ignored in this state.
- **S_DONE:**
  - `c_out` = `carry_q`.
  - Result registers hold while `out_ready` is low.
  - On `out_ready`, go to S_IDLE. There is no same-cycle re-accept, because `in_ready` is low in S_DONE.
- Arithmetic is modulo 2^W; `c_out` is the true unsigned carry of a + b + c_in.
- Changes to `a`, `b` or `c_in` after the accept edge have no effect on the operation in flight.
- `sum` contents are meaningful only while `out_valid` is high. During S_BUSY, `sum` is partially updated.
- **Reset:**
  - At any time, including mid-S_BUSY, reset forces S_IDLE.
  - `out_valid` = 0, `sum` = 0, `c_out`/`carry_q` = 0, `idx` = 0, operand registers = 0.
  - The operation in flight is discarded and no result is produced.

## Timing
- Accept at edge E0. Chunks are written at edges E1…E_CHUNKS. `out_valid` rises after E_CHUNKS, so latency is CHUNKS cycles.
- With `out_ready` held high: handshake at E_CHUNKS+1, next accept at E_CHUNKS+2. Peak throughput is one operation per CHUNKS+2 cycles.
- With CHUNKS = 1: one S_BUSY cycle, latency 1.
- `in_ready` and `out_valid` are decoded from registered state only, with no combinational input-to-output paths.
- The carry path per cycle is one N-bit ripple.

## Configuration
- **`WIDE_ADDER_SEQ_SUB_EN` defined:**
  - Adds the `sub` port, latched at accept.
  - When `sub_q` = 1, every b chunk is bitwise inverted before the adder, and `carry_q` is loaded with 1 (`c_in` ignored). The result is a − b; `c_out` = 1 means no borrow.
- **Macro undefined:** the port and inversion logic are absent, and the block is add-only.

## Structure
- Package `wide_adder_seq_pkg` holds:
  - `state_t` enum (S_IDLE, S_BUSY, S_DONE).
  - Localparam helper for the counter width, max(1, $clog2(CHUNKS)).
- The only sub-module is one `adder_n #(.N(N))` instance, shared across chunks. No other hierarchy.

## Test plan
All scenarios use N=8, CHUNKS=4 (W=32).
- **Reset:** assert `rst` for 3 cycles, then release → `out_valid`=0, `sum`=0, `c_out`=0, `in_ready`=1 on the first post-reset cycle.
- **Full-width carry ripple:** a=0xFFFFFFFF, b=0x00000001, c_in=0 → after exactly 4 cycles, `out_valid`=1, `sum`=0x00000000, `c_out`=1.
- **Carry-in, inputs changed after accept:** a=0x12345678, b=0x11111111, c_in=1, then change `a` to 0 the cycle after accept → `sum`=0x2345678A, `c_out`=0.
- **Backpressure:** `out_ready`=0 for 5 cycles after `out_valid`, with `in_valid`=1 and new operands driven throughout → result stable, `in_ready`=0, no second accept. Raising `out_ready` yields S_IDLE one cycle later, and the next accept occurs on the following edge.
- **Reset mid-operation:** assert `rst` after 2 chunks of 0xFFFFFFFF+0x1 → immediately S_IDLE, `out_valid`=0, `sum`=0. No `out_valid` pulse follows the release of reset.
- **Subtract (with `WIDE_ADDER_SEQ_SUB_EN`):** a=0x00000005, b=0x00000007, sub=1 → `sum`=0xFFFFFFFE, `c_out`=0. Then a=7, b=5, sub=1 → `sum`=0x00000002, `c_out`=1.

Source files
------------

// File: rtl/wide_adder_seq_pkg.sv
// wide_adder_seq_pkg
// Shared types and helpers for the wide_adder_seq chunk-serial adder.
//   state_t   : sequencer states (idle / busy adding chunks / result held)
//   cnt_width : width of the chunk index counter, never less than one bit
// Optional feature macro used by this block: WIDE_ADDER_SEQ_SUB_EN (adds a - b).
package wide_adder_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // A single-chunk configuration still needs a one-bit index register.
  function automatic int cnt_width(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

  localparam int DEFAULT_CHUNKS = 4;
  localparam int DEFAULT_IDX_W  = cnt_width(DEFAULT_CHUNKS);

endpackage

// File: rtl/wide_adder_seq_adder_n.sv
// adder_n
// Plain N-bit ripple adder with carry in and carry out. One instance is
// time-shared by wide_adder_seq across all chunks of a wide operand.
// Ports:
//   a, b  [N-1:0] : chunk operands
//   c_in          : carry into bit 0
//   sum   [N-1:0] : chunk sum
//   c_out         : carry out of bit N-1
module adder_n #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  // Extend by one bit so the carry out falls out of the addition directly.
  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};

endmodule

// File: rtl/wide_adder_seq.sv
// wide_adder_seq
// Adds two W = N*CHUNKS bit operands one N-bit chunk per clock, LSB chunk
// first, through a single shared adder_n with a registered inter-chunk carry.
// Latency is CHUNKS cycles from accept to out_valid.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : request handshake (ready only while idle)
//   a, b [W-1:0], c_in    : operands and carry into bit 0, latched at accept
//   sub                   : only with WIDE_ADDER_SEQ_SUB_EN; selects a - b
//   out_valid / out_ready : result handshake (valid while the result is held)
//   sum [W-1:0], c_out    : result register and carry out of bit W-1
// Configuration macro: WIDE_ADDER_SEQ_SUB_EN (undefined = add-only build).
module wide_adder_seq
  import wide_adder_seq_pkg::*;
#(
  parameter int N      = 32,
  parameter int CHUNKS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*CHUNKS-1:0] a,
  input  logic [N*CHUNKS-1:0] b,
  input  logic                c_in,
`ifdef WIDE_ADDER_SEQ_SUB_EN
  input  logic                sub,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*CHUNKS-1:0] sum,
  output logic                c_out
);

  localparam int W  = N * CHUNKS;
  localparam int IW = cnt_width(CHUNKS);
  localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            carry_q;
  logic [IW-1:0]   idx;
`ifdef WIDE_ADDER_SEQ_SUB_EN
  logic            sub_q;
`endif

  logic [N-1:0]    chunk_a;
  logic [N-1:0]    chunk_b;
  logic [N-1:0]    add_sum;
  logic            add_carry;

  // Handshake flags decode registered state only; reset also masks in_ready
  // so nothing can be accepted while reset is asserted.
  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE);
  assign c_out     = carry_q;

  // Select the current chunk of each latched operand for the shared adder.
  // Subtraction is a + ~b + 1, so the b chunk is inverted here and the +1
  // arrives through the carry loaded at accept.
  always_comb begin
    chunk_a = a_q[idx*N +: N];
    chunk_b = b_q[idx*N +: N];
`ifdef WIDE_ADDER_SEQ_SUB_EN
    if (sub_q) begin
      chunk_b = ~b_q[idx*N +: N];
    end
`endif
  end

  adder_n #(.N(N)) u_adder (
    .a     (chunk_a),
    .b     (chunk_b),
    .c_in  (carry_q),
    .sum   (add_sum),
    .c_out (add_carry)
  );

  // Sequencer: latch operands on accept, write one chunk per cycle while busy,
  // then hold the result until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      sum     <= '0;
`ifdef WIDE_ADDER_SEQ_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            idx   <= '0;
            state <= S_BUSY;
`ifdef WIDE_ADDER_SEQ_SUB_EN
            sub_q   <= sub;
            carry_q <= sub ? 1'b1 : c_in;
`else
            carry_q <= c_in;
`endif
          end
        end
        S_BUSY: begin
          sum[idx*N +: N] <= add_sum;
          carry_q         <= add_carry;
          idx             <= idx + IW'(1);
          if (idx == LAST_IDX) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wide_adder_seq.sv
// tb_wide_adder_seq
// Self-checking bench for wide_adder_seq with N=8, CHUNKS=4 (W=32).
// Directed scenarios (reset, full carry ripple, carry-in with operand change
// after accept, backpressure, reset mid-operation, optional subtract) are
// followed by randomized operations checked against an arithmetic model.
// Honors WIDE_ADDER_SEQ_SUB_EN when the design is built with it.
module tb_wide_adder_seq;

  localparam int N      = 8;
  localparam int CHUNKS = 4;
  localparam int W      = N * CHUNKS;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          c_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          c_out;
`ifdef WIDE_ADDER_SEQ_SUB_EN
  logic          sub;
`endif

  int errors = 0;
  int checks = 0;

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  wide_adder_seq #(.N(N), .CHUNKS(CHUNKS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
`ifdef WIDE_ADDER_SEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out)
  );

  // Reference: {carry, sum} straight from unsigned arithmetic on whole operands.
  function automatic logic [W:0] refModel(input logic [W-1:0] av, input logic [W-1:0] bv,
                                          input logic cv, input logic sv);
    logic [W:0] r;
    r = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
`ifdef WIDE_ADDER_SEQ_SUB_EN
    if (sv) begin
      r = {(av >= bv), av - bv};
    end
`endif
    return r;
  endfunction

  // One comparison: count it, and on mismatch count and report it.
  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Present an operation, wait (bounded) for in_ready, accept on the next edge,
  // then scramble the operand inputs to prove they are no longer used.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic cv, input logic sv, input string tag);
    int n;
    a        = av;
    b        = bv;
    c_in     = cv;
`ifdef WIDE_ADDER_SEQ_SUB_EN
    sub      = sv;
`endif
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checkValue({tag, "/in_ready_before_accept"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    c_in     = ~cv;
`ifdef WIDE_ADDER_SEQ_SUB_EN
    sub      = ~sv;
`endif
    if (sv === 1'bx) begin
      in_valid = 1'b0;
    end
  endtask

  // Called right after the accept edge: wait (bounded) for out_valid, check
  // latency and result, and optionally complete the output handshake.
  task automatic checkOutput(input logic [W:0] expv, input bit release_now, input string tag);
    int cycles;
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkValue({tag, "/latency"}, 64'(cycles), 64'(CHUNKS));
    checkValue({tag, "/sum"}, 64'(sum), 64'(expv[W-1:0]));
    checkValue({tag, "/c_out"}, 64'(c_out), 64'(expv[W]));
    if (release_now) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkValue({tag, "/valid_drops"}, 64'(out_valid), 64'd0);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb, na, nb;
    logic         rc, nc, rs, seen;
    logic [W:0]   expv;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;
`ifdef WIDE_ADDER_SEQ_SUB_EN
    sub       = 1'b0;
`endif

    // Reset held for three cycles, checked on the first cycle after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkValue("reset/out_valid", 64'(out_valid), 64'd0);
    checkValue("reset/sum", 64'(sum), 64'd0);
    checkValue("reset/c_out", 64'(c_out), 64'd0);
    checkValue("reset/in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Carry ripples through every chunk.
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "ripple");
    checkOutput({1'b1, 32'h0000_0000}, 1'b1, "ripple");

    // Carry-in used; a forced to zero after the accept edge.
    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, "cin");
    a = '0;
    checkOutput({1'b0, 32'h2345_678A}, 1'b1, "cin");

    // Backpressure: result must hold and no new accept while out_ready is low.
    ra = $urandom; rb = $urandom; rc = 1'($urandom);
    expv = refModel(ra, rb, rc, 1'b0);
    applyStimulus(ra, rb, rc, 1'b0, "bp");
    checkOutput(expv, 1'b0, "bp");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a        = $urandom;
      b        = $urandom;
      c_in     = 1'($urandom);
      @(posedge clk); #1;
      checkValue($sformatf("bp/hold%0d_sum", i), 64'(sum), 64'(expv[W-1:0]));
      checkValue($sformatf("bp/hold%0d_valid", i), 64'(out_valid), 64'd1);
      checkValue($sformatf("bp/hold%0d_in_ready", i), 64'(in_ready), 64'd0);
    end
    na = $urandom; nb = $urandom; nc = 1'($urandom);
    a = na; b = nb; c_in = nc;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkValue("bp/release_valid", 64'(out_valid), 64'd0);
    checkValue("bp/release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    checkValue("bp/next_accepted", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    a = $urandom;
    checkOutput(refModel(na, nb, nc, 1'b0), 1'b1, "bp_next");

    // Reset after two chunks discards the operation.
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "midrst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkValue("midrst/out_valid", 64'(out_valid), 64'd0);
    checkValue("midrst/sum", 64'(sum), 64'd0);
    checkValue("midrst/c_out", 64'(c_out), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    checkValue("midrst/no_valid_after", 64'(seen), 64'd0);
    checkValue("midrst/in_ready", 64'(in_ready), 64'd1);

`ifdef WIDE_ADDER_SEQ_SUB_EN
    // Subtraction with and without borrow.
    applyStimulus(32'd5, 32'd7, 1'b0, 1'b1, "sub_borrow");
    checkOutput({1'b0, 32'hFFFF_FFFE}, 1'b1, "sub_borrow");
    applyStimulus(32'd7, 32'd5, 1'b0, 1'b1, "sub_noborrow");
    checkOutput({1'b1, 32'h0000_0002}, 1'b1, "sub_noborrow");
`endif

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom);
      rs = 1'b0;
`ifdef WIDE_ADDER_SEQ_SUB_EN
      rs = 1'($urandom);
`endif
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      applyStimulus(ra, rb, rc, rs, $sformatf("rand%0d", i));
      checkOutput(refModel(ra, rb, rc, rs), 1'b1, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
